// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue front end: PC register, req/ack imem fetch, field split and valid/ready issue.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_issue #(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_ack,
   output logic              instr_valid,
   input  logic              issue_ready,
   output logic [5:0]        op_code,
   output logic [5:0]        func_code,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [15:0]       imm16,
   output logic [ADDR_W-1:0] pc_out,
   input  logic              Branch,
   input  logic              PC_WE,
   input  logic              alu_zero,
   output logic              halted,
   output logic              fetch_err,
   output logic [31:0]       instr_count
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ISSUE, S_HALT} state_t;

   localparam logic [5:0] OP_HALT = 6'b111111;

   state_t                   state;
   logic [ADDR_W-1:0]        pc;
   logic [31:0]              instr;
   logic [ADDR_W-1:0]        pc_seq;
   logic [ADDR_W-1:0]        pc_br;
   logic signed [ADDR_W-1:0] br_off;

   if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("RESET_PC must be word aligned");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] tcnt;
`else
   assign fetch_err = 1'b0;
`endif

   // Word offset of a taken branch, sign-extended to the PC width; wraps modulo 2^ADDR_W.
   assign br_off    = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
   assign pc_seq    = pc + ADDR_W'(4);
   assign pc_br     = pc_seq + $unsigned(br_off);

   assign imem_addr = pc;
   assign pc_out    = pc;
   assign op_code   = instr[31:26];
   assign rs        = instr[25:21];
   assign rt        = instr[20:16];
   assign rd        = instr[15:11];
   assign imm16     = instr[15:0];
   assign func_code = instr[5:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         instr       <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         instr_count <= '0;
`ifdef FETCH_TIMEOUT_EN
         tcnt        <= '0;
         fetch_err   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               state    <= S_REQ;
               imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
               tcnt     <= '0;
`endif
            end
            S_REQ: begin
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  state       <= S_ISSUE;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (tcnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  state     <= S_HALT;
                  imem_req  <= 1'b0;
                  halted    <= 1'b1;
                  fetch_err <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
`endif
            end
            S_ISSUE: begin
               if (issue_ready) begin
                  instr_valid <= 1'b0;
                  instr_count <= instr_count + 32'd1;
                  if (instr[31:26] == OP_HALT) begin
                     state  <= S_HALT;
                     halted <= 1'b1;
                  end else begin
                     // Without PC_WE the same word is refetched.
                     state    <= S_REQ;
                     imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                     tcnt     <= '0;
`endif
                     if (PC_WE) pc <= (Branch && alu_zero) ? pc_br : pc_seq;
                  end
               end
            end
            default: begin
               state <= S_HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue: directed scenarios plus a randomized run
// against a transaction-level PC/count model.
module tb_instr_fetch_issue;

   localparam logic [31:0] W_ADD  = 32'h012A4020;
   localparam logic [31:0] W_BEQ  = 32'h1109FFFE;
   localparam logic [31:0] W_HALT = 32'hFC000000;

   logic        clk, rst;
   logic        imem_req, imem_ack, instr_valid, issue_ready;
   logic [31:0] imem_addr, imem_rdata, pc_out, instr_count;
   logic [5:0]  op_code, func_code;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm16;
   logic        branch, pc_we, alu_zero, halted, fetch_err;

   logic        imem_req2, imem_ack2, instr_valid2, halted2, fetch_err2;
   logic [31:0] imem_addr2, pc_out2, instr_count2;
   logic [5:0]  op_code2, func_code2;
   logic [4:0]  rs2, rt2, rd2;
   logic [15:0] imm16_2;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem [logic [31:0]];
   logic        mem_ack = 1'b0, man_ack = 1'b0, auto_mem = 1'b1;
   int          ack_delay = 0, max_delay = 0, wcnt = 0;

   assign imem_ack  = auto_mem ? mem_ack : man_ack;
   assign imem_ack2 = imem_req2;

   instr_fetch_issue dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ack(imem_ack), .instr_valid(instr_valid),
      .issue_ready(issue_ready), .op_code(op_code), .func_code(func_code),
      .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .pc_out(pc_out),
      .Branch(branch), .PC_WE(pc_we), .alu_zero(alu_zero), .halted(halted),
      .fetch_err(fetch_err), .instr_count(instr_count)
   );

   instr_fetch_issue #(.RESET_PC(32'hFFFFFFFC)) dut2 (
      .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_rdata(W_ADD), .imem_ack(imem_ack2), .instr_valid(instr_valid2),
      .issue_ready(1'b1), .op_code(op_code2), .func_code(func_code2),
      .rs(rs2), .rt(rt2), .rd(rd2), .imm16(imm16_2), .pc_out(pc_out2),
      .Branch(1'b0), .PC_WE(1'b1), .alu_zero(1'b0), .halted(halted2),
      .fetch_err(fetch_err2), .instr_count(instr_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h00000020;
   endfunction

   // Memory responder: acks after ack_delay request cycles, delay re-drawn while idle.
   always @(negedge clk) begin
      if (imem_req) begin
         if (wcnt >= ack_delay) begin
            mem_ack    = 1'b1;
            imem_rdata = mem_read(imem_addr);
            wcnt       = 0;
         end else begin
            mem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         mem_ack   = 1'b0;
         wcnt      = 0;
         ack_delay = $urandom_range(max_delay, 0);
      end
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      issue_ready = 1'($urandom_range(1, 0));
      pc_we = 1'b1; branch = 1'b1; alu_zero = 1'b1;
      tick;
      tick;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fetch_err); end
      n_checks++; if (instr_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", instr_count); end
      n_checks++; if ({op_code, func_code, rs, rt, rd, imm16} !== 43'd0) begin
         n_fail++; $display("FAIL reset_fields: got %h want 0", {op_code, func_code, rs, rt, rd, imm16}); end
      n_checks++; if (pc_out !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc_out); end
      rst = 1'b0;
   endtask

   task automatic test_add;
      mem.delete(); mem[0] = W_ADD;
      max_delay = 0; auto_mem = 1'b1;
      issue_ready = 1'b1; pc_we = 1'b1; branch = 1'b0; alu_zero = 1'b0;
      do_reset;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL add_cyc0_req: got %b want 0", imem_req); end
      tick;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
         n_fail++; $display("FAIL add_cyc1_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
      tick;
      n_checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL add_cyc2_valid: got valid=%b req=%b want 1/0", instr_valid, imem_req); end
      n_checks++; if ({op_code, func_code, rs, rt, rd} !== {6'd0, 6'h20, 5'd9, 5'd10, 5'd8}) begin
         n_fail++; $display("FAIL add_fields: got op=%h fn=%h rs=%0d rt=%0d rd=%0d want 0/20/9/10/8", op_code, func_code, rs, rt, rd); end
      tick;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin
         n_fail++; $display("FAIL add_next_addr: got req=%b addr=%h want 1/4", imem_req, imem_addr); end
      n_checks++; if (instr_count !== 32'd1) begin n_fail++; $display("FAIL add_count: got %0d want 1", instr_count); end
   endtask

   task automatic test_beq(input logic zero, input logic [31:0] exp_addr);
      bit found = 0;
      mem.delete(); mem[32'h10] = W_BEQ;
      max_delay = 0; auto_mem = 1'b1;
      issue_ready = 1'b1; pc_we = 1'b1; branch = 1'b0; alu_zero = 1'b0;
      do_reset;
      for (int i = 0; i < 60 && !found; i++) begin
         tick;
         if (instr_valid && pc_out == 32'h10) found = 1;
      end
      n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL beq_reach: got found=%b want 1", found); end
      n_checks++; if (op_code !== 6'd4 || imm16 !== 16'hFFFE) begin
         n_fail++; $display("FAIL beq_fields: got op=%h imm=%h want 4/fffe", op_code, imm16); end
      branch = 1'b1; alu_zero = zero;
      tick;
      branch = 1'b0; alu_zero = 1'b0;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
         n_fail++; $display("FAIL beq_target_z%0d: got req=%b addr=%h want 1/%h", zero, imem_req, imem_addr, exp_addr); end
   endtask

   task automatic test_stall;
      bit found = 0;
      mem.delete(); mem[0] = W_ADD;
      max_delay = 0; auto_mem = 1'b1;
      issue_ready = 1'b0; pc_we = 1'b1; branch = 1'b0; alu_zero = 1'b0;
      do_reset;
      for (int i = 0; i < 10 && !found; i++) begin
         tick;
         if (instr_valid) found = 1;
      end
      n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got found=%b want 1", found); end
      for (int i = 0; i < 5; i++) begin
         if (i != 0) tick;
         n_checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold%0d: got valid=%b req=%b want 1/0", i, instr_valid, imem_req); end
         n_checks++; if (func_code !== 6'h20 || rd !== 5'd8 || instr_count !== 32'd0) begin
            n_fail++; $display("FAIL stall_data%0d: got fn=%h rd=%0d cnt=%0d want 20/8/0", i, func_code, rd, instr_count); end
      end
      issue_ready = 1'b1;
      tick;
      n_checks++; if (instr_count !== 32'd1 || imem_addr !== 32'd4 || imem_req !== 1'b1) begin
         n_fail++; $display("FAIL stall_release: got cnt=%0d addr=%h req=%b want 1/4/1", instr_count, imem_addr, imem_req); end
   endtask

   task automatic test_ack_delay;
      mem.delete(); mem[0] = W_ADD;
      max_delay = 0; auto_mem = 1'b1;
      issue_ready = 1'b1; pc_we = 1'b1; branch = 1'b0; alu_zero = 1'b0;
      do_reset;
      tick;
      tick;
      auto_mem = 1'b0; man_ack = 1'b0;
      tick;
      for (int i = 0; i < 3; i++) begin
         if (i != 0) tick;
         n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL wait_hold%0d: got req=%b addr=%h valid=%b want 1/4/0", i, imem_req, imem_addr, instr_valid); end
      end
      rst = 1'b1;
      tick;
      n_checks++; if (imem_req !== 1'b0 || pc_out !== 32'd0 || imem_addr !== 32'd0) begin
         n_fail++; $display("FAIL wait_reset: got req=%b pc=%h addr=%h want 0/0/0", imem_req, pc_out, imem_addr); end
      rst = 1'b0; man_ack = 1'b1;
      tick;
      man_ack = 1'b0;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr_valid !== 1'b0) begin
         n_fail++; $display("FAIL late_ack_a: got req=%b addr=%h valid=%b want 1/0/0", imem_req, imem_addr, instr_valid); end
      tick;
      n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
         n_fail++; $display("FAIL late_ack_b: got valid=%b req=%b want 0/1", instr_valid, imem_req); end
      auto_mem = 1'b1;
   endtask

   task automatic test_halt;
      mem.delete(); mem[0] = W_HALT;
      max_delay = 0; auto_mem = 1'b1;
      issue_ready = 1'b1; pc_we = 1'b1; branch = 1'b0; alu_zero = 1'b0;
      do_reset;
      tick;
      tick;
      n_checks++; if (instr_valid !== 1'b1 || op_code !== 6'h3F) begin
         n_fail++; $display("FAIL halt_issue: got valid=%b op=%h want 1/3f", instr_valid, op_code); end
      tick;
      for (int i = 0; i < 20; i++) begin
         n_checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_hold%0d: got halted=%b req=%b valid=%b want 1/0/0", i, halted, imem_req, instr_valid); end
         tick;
      end
      n_checks++; if (instr_count !== 32'd1) begin n_fail++; $display("FAIL halt_count: got %0d want 1", instr_count); end
   endtask

   task automatic test_pc_wrap;
      do_reset;
      n_checks++; if (imem_req2 !== 1'b0) begin n_fail++; $display("FAIL wrap_cyc0: got req=%b want 0", imem_req2); end
      tick;
      n_checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFFFFFC) begin
         n_fail++; $display("FAIL wrap_first: got req=%b addr=%h want 1/fffffffc", imem_req2, imem_addr2); end
      tick;
      n_checks++; if (instr_valid2 !== 1'b1 || pc_out2 !== 32'hFFFFFFFC) begin
         n_fail++; $display("FAIL wrap_issue: got valid=%b pc=%h want 1/fffffffc", instr_valid2, pc_out2); end
      tick;
      n_checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'd0) begin
         n_fail++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0", imem_req2, imem_addr2); end
   endtask

   task automatic test_timeout;
      auto_mem = 1'b0; man_ack = 1'b0;
      issue_ready = 1'b1; pc_we = 1'b1;
      do_reset;
`ifdef FETCH_TIMEOUT_EN
      for (int i = 1; i <= 16; i++) begin
         tick;
         n_checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
            n_fail++; $display("FAIL to_wait%0d: got req=%b err=%b want 1/0", i, imem_req, fetch_err); end
      end
      tick;
      n_checks++; if (fetch_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL to_expire: got err=%b halted=%b req=%b want 1/1/0", fetch_err, halted, imem_req); end
`else
      for (int i = 1; i <= 20; i++) begin
         tick;
         n_checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL to_wait%0d: got req=%b err=%b halted=%b want 1/0/0", i, imem_req, fetch_err, halted); end
      end
`endif
      auto_mem = 1'b1;
   endtask

   task automatic test_random;
      logic [31:0] mpc, mcount, w;
      int          off;
      mem.delete();
      for (int a = 0; a < 256; a++) begin
         w = $urandom;
         if (w[31:26] == 6'h3F) w[31] = 1'b0;
         mem[32'(a * 4)] = w;
      end
      max_delay = 3; auto_mem = 1'b1;
      issue_ready = 1'b0; pc_we = 1'b0; branch = 1'b0; alu_zero = 1'b0;
      do_reset;
      mpc = 32'd0; mcount = 32'd0; w = 32'd0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         tick;
         if (imem_req) begin
            n_checks++; if (imem_addr !== mpc || instr_valid !== 1'b0) begin
               n_fail++; $display("FAIL rnd_fetch@%0d: got addr=%h valid=%b want %h/0", cyc, imem_addr, instr_valid, mpc); end
         end
         if (instr_valid) begin
            w = mem_read(mpc);
            n_checks++; if ({op_code, rs, rt, rd, func_code, imm16} !== {w[31:26], w[25:21], w[20:16], w[15:11], w[5:0], w[15:0]}) begin
               n_fail++; $display("FAIL rnd_fields@%0d: got %h want %h", cyc, {op_code, rs, rt, rd, func_code, imm16},
                                  {w[31:26], w[25:21], w[20:16], w[15:11], w[5:0], w[15:0]}); end
            n_checks++; if (pc_out !== mpc || instr_count !== mcount) begin
               n_fail++; $display("FAIL rnd_state@%0d: got pc=%h cnt=%0d want %h/%0d", cyc, pc_out, instr_count, mpc, mcount); end
         end
         issue_ready = ($urandom_range(3, 0) != 0);
         pc_we       = ($urandom_range(3, 0) != 0);
         branch      = 1'($urandom_range(1, 0));
         alu_zero    = 1'($urandom_range(1, 0));
         if (instr_valid && issue_ready) begin
            mcount = mcount + 32'd1;
            if (pc_we) begin
               off = int'($signed(w[15:0]));
               if (branch && alu_zero) mpc = mpc + 32'd4 + 32'(off * 4);
               else                    mpc = mpc + 32'd4;
            end
         end
      end
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rnd_halted: got %b want 0", halted); end
      issue_ready = 1'b0; pc_we = 1'b0; branch = 1'b0; alu_zero = 1'b0;
   endtask

   initial begin
      rst = 1'b1; issue_ready = 1'b0; pc_we = 1'b0; branch = 1'b0; alu_zero = 1'b0;
      imem_rdata = 32'd0;
      test_reset;
      test_add;
      test_beq(1'b1, 32'h0000000C);
      test_beq(1'b0, 32'h00000014);
      test_stall;
      test_ack_delay;
      test_halt;
      test_pc_wrap;
      test_timeout;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
